ikaopm_acc: RTL



---
 rtl/ikaopm_pkg.sv | 12 +
 rtl/ikaopm_acc_sat.sv | 32 +++
 rtl/ikaopm_acc.sv | 93 +++++++++
 3 files changed

// File: rtl/ikaopm_pkg.sv
// Shared constants for the sound accumulator stage.
// Pure declarations: no logic and no latency.
// Nothing here takes or applies backpressure.
package ikaopm_pkg;
  localparam int ACC_WIDTH    = 18;  // 8 x 14-bit sign-extended samples fit with headroom
  localparam int OUT_WIDTH    = 16;
  localparam int SAMPLE_WIDTH = 14;
  localparam int NOISE_SLOT   = 31;
  localparam int SLOT_LAST    = 31;
  localparam int RL_L         = 1;   // i_RL bit enabling the left side
  localparam int RL_R         = 0;   // i_RL bit enabling the right side
endpackage

// File: rtl/ikaopm_acc_sat.sv
// Signed saturator from IN_W down to OUT_W bits (clamps to the OUT_W signed range).
// Combinational, zero latency.
// No handshake; the output follows the input.
module ikaopm_acc_sat
  import ikaopm_pkg::*;
#(
  parameter int IN_W  = ACC_WIDTH,
  parameter int OUT_W = OUT_WIDTH
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  // The value fits when every bit from the sign down to the output's sign bit agrees.
  logic [IN_W-OUT_W:0] upper;
  logic                fits;

  assign upper = din[IN_W-1:OUT_W-1];
  assign fits  = (&upper) | ~(|upper);

  // Pass through when representable, otherwise clamp toward the input's sign.
  always_comb begin
    if (fits) begin
      dout = din[OUT_W-1:0];
    end else if (din[IN_W-1]) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ikaopm_acc.sv
// Per-frame left/right carrier accumulator with noise-slot substitution and 16-bit saturated output.
// Sample appears on the first phi1 PCEN enable after the i_CYCLE_31 NCEN enable (half a phi1 cycle).
// No backpressure: the DAC side must take each o_SAMPLE_VALID pulse; the next one overwrites it.
module ikaopm_acc #(
  parameter int ACC_WIDTH  = ikaopm_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH  = ikaopm_pkg::OUT_WIDTH,
  parameter int NOISE_SLOT = ikaopm_pkg::NOISE_SLOT
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_MRST_n,
  input  logic                 i_phi1_PCEN_n,
  input  logic                 i_phi1_NCEN_n,
  input  logic                 i_CYCLE_31,
  input  logic                 i_SNDADD,
  input  logic [13:0]          i_OPDATA,
  input  logic [13:0]          i_ACC_NOISE,
  input  logic                 i_NE,
  input  logic [1:0]           i_RL,
  output logic [OUT_WIDTH-1:0] o_LEFT,
  output logic [OUT_WIDTH-1:0] o_RIGHT,
  output logic                 o_SAMPLE_VALID,
  output logic [4:0]           o_SLOT
);
  import ikaopm_pkg::*;

  logic [4:0]           slot;
  logic [ACC_WIDTH-1:0] acc_l, acc_r;
  logic [ACC_WIDTH-1:0] sum_l, sum_r;
  logic [ACC_WIDTH-1:0] src_ext;
  logic [13:0]          src;
  logic [OUT_WIDTH-1:0] sat_l, sat_r;
  logic [OUT_WIDTH-1:0] stage_l, stage_r;
  logic                 pending;
  logic                 use_noise;
  logic                 ncen, pcen;

  assign ncen = ~i_phi1_NCEN_n;
  assign pcen = ~i_phi1_PCEN_n;

  // The noise word only replaces the operator sample; it still needs i_SNDADD to be counted.
  assign use_noise = (slot == 5'(NOISE_SLOT)) && i_NE;
  assign src       = use_noise ? i_ACC_NOISE : i_OPDATA;
  assign src_ext   = {{(ACC_WIDTH-SAMPLE_WIDTH){src[SAMPLE_WIDTH-1]}}, src};

  // Running sums including this slot's contribution, used both for accumulation and frame end.
  always_comb begin
    sum_l = acc_l;
    sum_r = acc_r;
    if (i_SNDADD && i_RL[RL_L]) sum_l = acc_l + src_ext;
    if (i_SNDADD && i_RL[RL_R]) sum_r = acc_r + src_ext;
  end

  ikaopm_acc_sat #(.IN_W(ACC_WIDTH), .OUT_W(OUT_WIDTH)) u_sat_l (.din(sum_l), .dout(sat_l));
  ikaopm_acc_sat #(.IN_W(ACC_WIDTH), .OUT_W(OUT_WIDTH)) u_sat_r (.din(sum_r), .dout(sat_r));

  // NCEN: advance slot, accumulate, stage at frame end. PCEN: publish staged sample as a one-phi1 pulse.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      slot           <= '0;
      acc_l          <= '0;
      acc_r          <= '0;
      stage_l        <= '0;
      stage_r        <= '0;
      pending        <= 1'b0;
      o_LEFT         <= '0;
      o_RIGHT        <= '0;
      o_SAMPLE_VALID <= 1'b0;
    end else if (ncen) begin
      slot <= (i_CYCLE_31 || slot == 5'(SLOT_LAST)) ? 5'd0 : slot + 5'd1;
      if (i_CYCLE_31) begin
        // Clear here so slot 0 of the next frame starts clean without counting this slot twice.
        acc_l   <= '0;
        acc_r   <= '0;
        stage_l <= sat_l;
        stage_r <= sat_r;
        pending <= 1'b1;
      end else begin
        acc_l <= sum_l;
        acc_r <= sum_r;
      end
    end else if (pcen) begin
      o_SAMPLE_VALID <= pending;
      if (pending) begin
        o_LEFT  <= stage_l;
        o_RIGHT <= stage_r;
        pending <= 1'b0;
      end
    end
  end

  assign o_SLOT = slot;

endmodule
